key_sched_ctrl: RTL
===================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter N_MUX, default 4, number of mux-select key bits (p1..p4).
REQ-002 SHALL have parameter N_XOR, default 26, number of XOR key bits (X_1..X_26).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key_in_valid  input  1  serial key beat valid.
REQ-006 SHALL have port key_in_bit  input  1  serial key data bit.
REQ-007 SHALL have port key_in_last  input  1  marks final beat of the load.
REQ-008 SHALL have port key_in_ready  output  1  beat accepted when valid&ready.
REQ-009 SHALL have port key_clear  input  1  synchronous zeroize/abort pulse.
REQ-010 SHALL have port key_mux  output  N_MUX  drives p[N_MUX:1] of locked netlist.
REQ-011 SHALL have port key_xor  output  N_XOR  drives X_[N_XOR:1] of locked netlist.
REQ-012 SHALL have port key_valid  output  1  key applied and stable.
REQ-013 SHALL have port key_err  output  1  last load rejected.
REQ-014 SHALL state: one clock; reset asynchronous, active-low.

Function
REQ-015 SHALL implement states IDLE, SHIFT, CHECK, ACTIVE, ERROR.
REQ-016 key_in_ready SHALL be 1 only in IDLE and SHIFT, registered, with no combinational path from key_in_valid.
REQ-017 Expected beat count NB SHALL be N_MUX+N_XOR (30), plus 1 when KEY_PARITY_EN is defined.
REQ-018 Each accepted beat SHALL shift left into a shift register and increment a beat counter; the first beat lands at the MSB, i.e., the first bit drives key_mux[N_MUX-1].
REQ-019 IDLE SHALL move to SHIFT on the first accepted beat; that beat SHALL be captured.
REQ-020 On an accepted beat with key_in_last=1: count == NB -> CHECK; otherwise -> ERROR.
REQ-021 An accepted beat without last when count already equals NB (overrun) SHALL -> ERROR.
REQ-022 CHECK SHALL last exactly one cycle, then go to ACTIVE (check passes) or ERROR.
REQ-023 Latency: last beat accepted at edge t; key_valid SHALL rise at edge t+2.
REQ-024 In ACTIVE, key_mux/key_xor SHALL hold the loaded value and key_valid=1 until key_clear.
REQ-025 Outside ACTIVE, key_mux, key_xor and key_valid SHALL be 0; partial keys are never exposed.
REQ-026 key_err SHALL be 1 in ERROR only; ERROR SHALL exit only by key_clear, to IDLE.
REQ-027 key_clear in any state SHALL go to IDLE and zero the shift register and counter; it SHALL take priority over a simultaneous beat, which is dropped.
REQ-028 key_in_valid in CHECK, ACTIVE or ERROR SHALL be ignored with no state change.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, the shift register and counter to 0, key_in_ready=0, key_valid=0, key_err=0, key_mux=0 and key_xor=0.
REQ-030 key_in_ready SHALL rise on the first clk edge after rst_n deasserts; reset during SHIFT SHALL discard the partial key.

Configuration
REQ-031 Macro KEY_PARITY_EN defined: one extra final beat SHALL carry odd parity over the 30 key bits, and CHECK SHALL pass only if the XOR of all 31 bits is 1.
REQ-032 Macro KEY_PARITY_EN undefined: NB SHALL be 30 and CHECK SHALL always pass.

Verification
REQ-033 No parity: 30 beats of 0x2AAAAAAA (MSB first), last on beat 30 -> key_mux=4'b1010, key_xor=26'h2AAAAAA, key_valid=1 two edges after the last beat.
REQ-034 Short load: last on beat 12 -> key_err=1, key_valid=0, outputs 0; key_clear -> IDLE, key_in_ready=1 next cycle.
REQ-035 Overrun: 31 beats with no last (no parity) -> ERROR on the 31st beat.
REQ-036 Parity build: 0x00000001 plus parity bit 0 -> ACTIVE; same key with parity bit 1 -> key_err=1.
REQ-037 key_clear asserted with a beat at count 15 -> IDLE, beat dropped; next full load succeeds.
REQ-038 rst_n pulsed low in ACTIVE -> all outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// Serial key loader for a locked netlist: shifts in NB beats MSB-first, checks them, then drives key_mux/key_xor.
// key_valid rises two edges after the last beat; key_in_ready is registered and low in CHECK/ACTIVE/ERROR. Optional odd-parity beat: KEY_PARITY_EN.
module key_sched_ctrl #(
    parameter int N_MUX = 4,
    parameter int N_XOR = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in_valid,
    input  logic             key_in_bit,
    input  logic             key_in_last,
    output logic             key_in_ready,
    input  logic             key_clear,
    output logic [N_MUX-1:0] key_mux,
    output logic [N_XOR-1:0] key_xor,
    output logic             key_valid,
    output logic             key_err
);
    localparam int KW = N_MUX + N_XOR;
`ifdef KEY_PARITY_EN
    localparam int NB = KW + 1;
`else
    localparam int NB = KW;
`endif
    // Sized to hold NB+1 so the post-increment compare never wraps.
    localparam int CW = $clog2(NB + 2);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACTIVE, ERROR} state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   key_q, key_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            accept;
    logic            check_pass;
    logic [CW-1:0]   cnt_inc;

    assign accept  = key_in_valid & ready_q;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef KEY_PARITY_EN
    assign check_pass = ^sreg_q;
`else
    assign check_pass = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (key_clear) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, SHIFT: begin
                    if (accept) begin
                        sreg_d = {sreg_q[NB-2:0], key_in_bit};
                        cnt_d  = cnt_inc;
                        if (key_in_last) begin
                            state_d = (cnt_inc == CW'(NB)) ? CHECK : ERROR;
                        end else if (cnt_q == CW'(NB)) begin
                            state_d = ERROR;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                CHECK:   state_d = check_pass ? ACTIVE : ERROR;
                default: state_d = state_q;
            endcase
        end

        ready_d = (state_d == IDLE) || (state_d == SHIFT);
        // One cycle of ACTIVE passes before the key is exposed, giving the two-edge latency.
        valid_d = (state_q == ACTIVE) && (state_d == ACTIVE);
        err_d   = (state_d == ERROR);
        key_d   = valid_d ? sreg_q[NB-1 -: KW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign key_in_ready = ready_q;
    assign key_valid    = valid_q;
    assign key_err      = err_q;
    assign key_mux      = key_q[KW-1 -: N_MUX];
    assign key_xor      = key_q[N_XOR-1:0];

endmodule
